// File: rtl/seq_memory_stage.sv
//==============================================================================
// seq_memory_stage : Y86-64 SEQ memory stage, byte-serial quadword RAM access
// Revision: 1.0
//==============================================================================
`default_nettype none

module seq_memory_stage #(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        icode,
   input  logic [63:0]       valA,
   input  logic [63:0]       valE,
   input  logic [63:0]       valP,
   output logic              busy,
   output logic              done,
   output logic [63:0]       valM,
   output logic [2:0]        stat,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data
);

   localparam logic [2:0] c_STAT_AOK = 3'd1;
   localparam logic [2:0] c_STAT_HLT = 3'd2;
   localparam logic [2:0] c_STAT_ADR = 3'd3;
   localparam logic [2:0] c_STAT_INS = 3'd4;
   localparam logic [63:0] c_ADDR_MAX = 64'(MEM_BYTES - 8);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SHORT} state_t;

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [63:0]       r_wdata;
   logic [63:0]       r_rdata;
   logic              r_write;
   logic [2:0]        r_pend_stat;
   logic              r_done;
   logic [63:0]       r_valm;
   logic [2:0]        r_stat;
   logic [7:0]        r_mem [MEM_BYTES];

   logic              w_is_mem, w_is_write, w_addr_bad, w_accept;
   logic [63:0]       w_addr, w_wdata;
   logic [2:0]        w_dec_stat;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_idx;
   logic [7:0]        w_mem_wd, w_rd_byte;

   always_comb begin
      w_is_mem   = 1'b0;
      w_is_write = 1'b0;
      w_addr     = valE;
      w_wdata    = valA;
      w_dec_stat = c_STAT_AOK;
      case (icode)
         4'h0: w_dec_stat = c_STAT_HLT;
         4'h1, 4'h2, 4'h3, 4'h6, 4'h7: w_dec_stat = c_STAT_AOK;
         4'h4: begin w_is_mem = 1'b1; w_is_write = 1'b1; end
         4'h5: w_is_mem = 1'b1;
         4'h8: begin w_is_mem = 1'b1; w_is_write = 1'b1; w_wdata = valP; end
         4'h9: begin w_is_mem = 1'b1; w_addr = valA; end
         4'hA: begin w_is_mem = 1'b1; w_is_write = 1'b1; end
         4'hB: begin w_is_mem = 1'b1; w_addr = valA; end
         default: w_dec_stat = c_STAT_INS;
      endcase
   end

   // The full 64-bit compare also rejects any address with upper bits set.
   assign w_addr_bad = (w_addr > c_ADDR_MAX);
   assign w_accept   = start && (r_state == S_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_state_nxt = (w_is_mem && !w_addr_bad) ? S_ACCESS : S_SHORT;
         end
         S_ACCESS: if (r_cnt == 3'd7) w_state_nxt = S_IDLE;
         S_SHORT:  w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // One RAM port shared by the byte sequencer and the idle-time preload.
   always_comb begin
      w_mem_we  = 1'b0;
      w_mem_idx = ld_addr;
      w_mem_wd  = ld_data;
      if (r_state == S_ACCESS) begin
         w_mem_idx = r_addr + ADDR_W'(r_cnt);
         w_mem_wd  = r_wdata[7:0];
         w_mem_we  = r_write;
      end else if (r_state == S_IDLE) begin
         w_mem_we  = ld_en;
      end
   end

   assign w_rd_byte = r_mem[w_mem_idx];

   always_ff @(posedge clk) begin
      if (w_mem_we)
         r_mem[w_mem_idx] <= w_mem_wd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= 3'd0;
         r_addr      <= '0;
         r_wdata     <= 64'd0;
         r_rdata     <= 64'd0;
         r_write     <= 1'b0;
         r_pend_stat <= c_STAT_AOK;
         r_done      <= 1'b0;
         r_valm      <= 64'd0;
         r_stat      <= c_STAT_AOK;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr      <= w_addr[ADDR_W-1:0];
                  r_wdata     <= w_wdata;
                  r_write     <= w_is_write;
                  r_cnt       <= 3'd0;
                  r_rdata     <= 64'd0;
                  r_pend_stat <= (w_is_mem && w_addr_bad) ? c_STAT_ADR : w_dec_stat;
               end
            end
            S_ACCESS: begin
               // Bytes arrive LSB first; shifting in at the top leaves byte 0 at the bottom.
               r_cnt   <= r_cnt + 3'd1;
               r_wdata <= r_wdata >> 8;
               r_rdata <= {w_rd_byte, r_rdata[63:8]};
               if (r_cnt == 3'd7) begin
                  r_done <= 1'b1;
                  r_valm <= r_write ? 64'd0 : {w_rd_byte, r_rdata[63:8]};
                  r_stat <= c_STAT_AOK;
               end
            end
            S_SHORT: begin
               r_done <= 1'b1;
               r_valm <= 64'd0;
               r_stat <= r_pend_stat;
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign valM = r_valm;
   assign stat = r_stat;

endmodule

`default_nettype wire

// File: tb/tb_seq_memory_stage.sv
//==============================================================================
// tb_seq_memory_stage : scoreboard bench for seq_memory_stage
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_seq_memory_stage;

   localparam int MB = 1024;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    icode = 4'h0;
   logic [63:0]   valA = 64'd0, valE = 64'd0, valP = 64'd0;
   logic          busy, done;
   logic [63:0]   valM;
   logic [2:0]    stat;
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [7:0]    ld_data = 8'd0;

   typedef struct {
      string       tag;
      logic [63:0] valm;
      logic [2:0]  stat;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   seq_memory_stage #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .icode(icode),
      .valA(valA), .valE(valE), .valP(valP),
      .busy(busy), .done(done), .valM(valM), .stat(stat),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_valM"}, valM, e.valm);
            chk({e.tag, "_stat"}, 64'(stat), 64'(e.stat));
            chk({e.tag, "_lat"}, 64'(cyc - e.acc), 64'(e.lat));
         end
      end
   end

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic issue(input string tag, input logic [3:0] ic, input logic [63:0] a,
                        input logic [63:0] e, input logic [63:0] p,
                        input logic [63:0] xm, input logic [2:0] xs, input int lat,
                        input logic ld, input logic [AW-1:0] la, input logic [7:0] ldat);
      exp_t x;
      @(negedge clk);
      start = 1'b1; icode = ic; valA = a; valE = e; valP = p;
      if (ld) begin ld_en = 1'b1; ld_addr = la; ld_data = ldat; end
      x.tag = tag; x.valm = xm; x.stat = xs; x.acc = cyc + 1; x.lat = lat;
      sb.push_back(x);
      @(negedge clk);
      start = 1'b0; ld_en = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         chk("timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   initial begin
      logic [63:0] w;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_valM", valM, 64'd0);
      chk("rst_stat", 64'(stat), 64'd1);

      w = 64'h1122334455667788;
      for (int i = 0; i < 8; i++) preload(AW'(32'h100 + i), w[8*i +: 8]);
      issue("mrmovq", 4'h5, 64'd0, 64'h100, 64'd0, w, 3'd1, 8, 1'b0, '0, 8'd0);
      chk("busy_during", 64'(busy), 64'd1);
      start = 1'b1; icode = 4'h0;
      @(negedge clk);
      start = 1'b0;
      drain();

      issue("pushq", 4'hA, 64'hDEADBEEFCAFEF00D, 64'h1F8, 64'd0, 64'd0, 3'd1, 8, 1'b0, '0, 8'd0);
      drain();
      issue("popq", 4'hB, 64'h1F8, 64'd0, 64'd0, 64'hDEADBEEFCAFEF00D, 3'd1, 8, 1'b0, '0, 8'd0);
      drain();

      // ret is driven during call's done cycle
      issue("call", 4'h8, 64'd0, 64'h200, 64'h42, 64'd0, 3'd1, 8, 1'b0, '0, 8'd0);
      repeat (7) @(negedge clk);
      issue("ret", 4'h9, 64'h200, 64'd0, 64'd0, 64'h42, 3'd1, 8, 1'b0, '0, 8'd0);
      drain();

      for (int i = 0; i < 8; i++) preload(AW'(MB - 8 + i), 8'(8'h80 + i));
      issue("rm_adr_top", 4'h4, 64'hFFFF_FFFF_FFFF_FFFF, 64'(MB - 4), 64'd0, 64'd0, 3'd3, 1, 1'b0, '0, 8'd0);
      drain();
      issue("rm_adr_hi", 4'h4, 64'd5, 64'h8000000000000000, 64'd0, 64'd0, 3'd3, 1, 1'b0, '0, 8'd0);
      drain();
      issue("mr_adr_m7", 4'h5, 64'd0, 64'(MB - 7), 64'd0, 64'd0, 3'd3, 1, 1'b0, '0, 8'd0);
      drain();
      issue("mr_top", 4'h5, 64'd0, 64'(MB - 8), 64'd0, 64'h8786858483828180, 3'd1, 8, 1'b0, '0, 8'd0);
      drain();

      issue("halt", 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 3'd2, 1, 1'b0, '0, 8'd0);
      drain();
      issue("ins_e", 4'hE, 64'd0, 64'd0, 64'd0, 64'd0, 3'd4, 1, 1'b0, '0, 8'd0);
      drain();
      issue("opq", 4'h6, 64'd0, 64'h100, 64'd0, 64'd0, 3'd1, 1, 1'b0, '0, 8'd0);
      drain();

      for (int i = 0; i < 8; i++) preload(AW'(32'h108 + i), 8'h00);
      issue("ld_same", 4'h5, 64'd0, 64'h108, 64'd0, 64'h5A, 3'd1, 8, 1'b1, AW'(32'h108), 8'h5A);
      drain();

      for (int i = 0; i < 4; i++) preload(AW'(32'h300 + i), 8'h00);
      for (int i = 4; i < 8; i++) preload(AW'(32'h300 + i), 8'(8'hA0 + i));
      @(negedge clk);
      start = 1'b1; icode = 4'h4; valE = 64'h300; valA = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      start = 1'b1; icode = 4'h0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_stat", 64'(stat), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      issue("after_abort", 4'h5, 64'd0, 64'h300, 64'd0, 64'hA7A6A5A4FFFFFFFF, 3'd1, 8, 1'b0, '0, 8'd0);
      drain();
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
